// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial pattern detector.
// Holds overlap mode encodings, legal pattern-length range and the saturating increment.
package seq_det_pkg;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    localparam int PAT_LEN_MIN = 2;
    localparam int PAT_LEN_MAX = 16;

    // Increment that sticks at the all-ones value of a counter that is 'width' bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (cnt >= max_val) ? max_val : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/match_counter.sv
// Saturating match counter; a clear wins over a coincident increment.
module match_counter
    import seq_det_pkg::*;
#(
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic               clr,
    output logic [COUNT_W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= COUNT_W'(sat_inc(32'(cnt), COUNT_W));
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with loadable pattern, overlap control and a saturating match count.
// Pattern MSB is the first bit received; w pulses the cycle after the last pattern bit is sampled.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                  PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0]  DEFAULT_PAT = 4'b1101,
    parameter int                  COUNT_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               b,
    input  logic               en,
    input  logic               overlap,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    input  logic               cnt_clr,
    output logic               w,
    output logic [COUNT_W-1:0] match_cnt,
    output logic               busy
);

    localparam int                FILL_W = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(PAT_LEN);

    if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN out of legal range");
    end

    logic [PAT_LEN-1:0] pattern;
    logic [PAT_LEN-1:0] hist;
    logic [FILL_W-1:0]  fill;

    logic [PAT_LEN-1:0] hist_n;
    logic [FILL_W-1:0]  fill_n;
    logic               hit;

    // Next history/fill if this edge samples a bit; a load on the same edge suppresses the hit.
    always_comb begin
        hist_n = {hist[PAT_LEN-2:0], b};
        fill_n = (fill == FULL) ? FULL : fill + 1'b1;
        hit    = en && !pat_load && (fill_n == FULL) && (hist_n == pattern);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pattern <= DEFAULT_PAT;
            hist    <= '0;
            fill    <= '0;
            w       <= 1'b0;
        end else if (pat_load) begin
            pattern <= pat_in;
            hist    <= '0;
            fill    <= '0;
            w       <= 1'b0;
        end else if (en) begin
            w <= hit;
            if (hit) begin
                unique case (overlap)
                    MODE_OVL: begin
                        hist <= hist_n;
                        fill <= FULL;
                    end
                    MODE_NONOVL: begin
                        hist <= '0;
                        fill <= '0;
                    end
                endcase
            end else begin
                hist <= hist_n;
                fill <= fill_n;
            end
        end else begin
            w <= 1'b0;
        end
    end

    assign busy = (fill != '0);

    match_counter #(
        .COUNT_W(COUNT_W)
    ) u_match_counter (
        .clk(clk),
        .rst(rst),
        .inc(hit),
        .clr(cnt_clr),
        .cnt(match_cnt)
    );

endmodule
